div_unit: RTL
=============

Name: div_unit

Overview:
Multi-cycle restoring divider that executes DIV/DIVU on behalf of the EX stage.
- Sits beside EX: EX supplies operands and a start strobe, holds the pipeline stalled while busy, and consumes the 64-bit {remainder, quotient} result for the HI/LO write path.
- Produces one quotient bit per clock.
- Supports signed and unsigned operation, divide-by-zero, and annulment by a pipeline flush.

Parameters:
- WIDTH, 32, operand width in bits; the result is 2*WIDTH bits.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous active-low reset.
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start_i.
- opdata1_i  in  WIDTH  dividend; sampled with start_i.
- opdata2_i  in  WIDTH  divisor; sampled with start_i.
- start_i  in  1  request. EX holds it high until it has consumed ready_o.
- annul_i  in  1  abort the current division (flush).
- result_o  out  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}; HI = remainder, LO = quotient.
- ready_o  out  1  result valid.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=FREE, cnt=0, result_o=0, ready_o=0, working registers=0.
  - Reset mid-operation discards all progress.
- All outputs are registered.
- FREE:
  - ready_o=0, result_o=0.
  - If start_i=1 and annul_i=0: latch operands and signedness.
    - Divisor == 0 → BYZERO.
    - Otherwise → ON, cnt=0.
  - Signed mode converts negative operands to magnitude (two's-complement negate) at latch time and records sign1 and sign2.
  - start_i with annul_i=1 is ignored (stays FREE).
- BYZERO: next edge → END with result=0.
- ON: one iteration per edge on a (2*WIDTH+1)-bit shift register.
  - Trial-subtract the divisor from the upper partial remainder.
  - Non-negative: commit the difference and shift in 1. Negative: shift in 0.
  - cnt increments each iteration.
  - annul_i=1 in any ON cycle → FREE on that edge; ready_o stays 0 and nothing is output.
  - When cnt == WIDTH (after WIDTH iterations), the next edge applies sign correction and goes → END:
    - Signed quotient is negated iff sign1 XOR sign2.
    - Signed remainder is negated iff sign1 (remainder takes the dividend's sign).
    - Unsigned: no correction.
- END:
  - ready_o=1; result_o holds the final value.
  - Stays in END while start_i=1 (EX is stall-holding).
  - start_i=0 → FREE; ready_o=0 and result_o=0 on that edge.
  - annul_i in END behaves like start_i=0.
- Latency:
  - Normal: ready_o is first high WIDTH+2 edges after the accepting edge (34 for WIDTH=32).
  - Divide-by-zero: 2 edges.
- Boundary cases:
  - Signed MIN/-1 yields quotient 0x80000000 (wraps), remainder 0. No exception.
  - A dividend smaller than the divisor yields quotient 0, remainder = dividend.
  - A new start_i is accepted only in FREE, so back-to-back divisions need one FREE cycle.
  - Operand inputs are ignored after the accepting edge.

Decomposition:
- Add to defines.v:
  - State encodings DivFree=2'b00, DivByZero=2'b01, DivOn=2'b10, DivEnd=2'b11.
  - DivResultReady/DivResultNotReady, DivStart/DivStop.
  - DoubleRegBus [63:0].
  - EXE_DIV_OP / EXE_DIVU_OP aluop codes.
- No sub-module: the per-cycle subtract/shift step is one combinational expression inside div_unit.

Test Plan:
- Unsigned 100 ÷ 7 → after 34 edges ready_o=1, result_o=0x00000002_0000000E; drop start_i → next edge ready_o=0, result_o=0.
- Signed −7 ÷ 2 (0xFFFFFFF9, 0x00000002) → result_o=0xFFFFFFFF_FFFFFFFD (r=−1, q=−3).
- Signed 0x80000000 ÷ 0xFFFFFFFF → result_o=0x00000000_80000000; unsigned 0xFFFFFFFF ÷ 1 → 0x00000000_FFFFFFFF.
- 5 ÷ 0 (either mode) → ready_o=1 two edges after start, result_o=0.
- Annul at iteration 10 → FREE next edge, ready_o never rises. A restart of 9 ÷ 4 then yields 0x00000001_00000002 after 34 edges. Pulse rst low at iteration 20 → outputs 0 immediately.
- Hold start_i high 5 extra cycles in END → ready_o and result_o stable throughout. start_i with annul_i=1 in FREE → no transition.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle divider: state encoding, handshake levels
// and the ALU op codes that route an instruction to the divider.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_t;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

    localparam int DOUBLE_REG_BUS_W = 64;
    typedef logic [DOUBLE_REG_BUS_W-1:0] double_reg_bus_t;

    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

    function automatic logic is_div_op(input logic [7:0] aluop);
        return (aluop == EXE_DIV_OP) || (aluop == EXE_DIVU_OP);
    endfunction

endpackage

// File: rtl/div_unit.sv
// Restoring divider for DIV/DIVU, one quotient bit per clock; result is
// {remainder, quotient} for the HI/LO write path.
//
// state       | meaning
// DIV_FREE    | idle, waiting for start_i (outputs zero)
// DIV_BY_ZERO | divisor was zero, result forced to zero
// DIV_ON      | iterating, cnt counts completed quotient bits
// DIV_END     | result valid, held while EX keeps start_i high
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

    div_state_t         state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [2*WIDTH:0]   work, work_d;
    logic [WIDTH-1:0]   divisor, divisor_d;
    logic               sign1, sign1_d;
    logic               sign2, sign2_d;
    logic [2*WIDTH-1:0] result_d;
    logic               ready_d;

    logic [WIDTH-1:0]   op1_mag, op2_mag;
    logic [2*WIDTH:0]   shifted;
    logic [WIDTH+1:0]   diff;
    logic [WIDTH-1:0]   quot, rem, quot_fix, rem_fix;
    logic               accept;

    // work holds {partial remainder (WIDTH+1 bits), dividend/quotient (WIDTH bits)}
    always_comb begin
        op1_mag  = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        op2_mag  = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
        shifted  = {work[2*WIDTH-1:0], 1'b0};
        diff     = {1'b0, shifted[2*WIDTH:WIDTH]} - {2'b00, divisor};
        quot     = work[WIDTH-1:0];
        rem      = work[2*WIDTH-1:WIDTH];
        quot_fix = (sign1 ^ sign2) ? -quot : quot;
        rem_fix  = sign1 ? -rem : rem;
        accept   = (start_i == DIV_START) && !annul_i;
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        work_d    = work;
        divisor_d = divisor;
        sign1_d   = sign1;
        sign2_d   = sign2;
        result_d  = '0;
        ready_d   = DIV_RESULT_NOT_READY;

        case (state)
            DIV_FREE: begin
                if (accept) begin
                    // sign flags are only ever set in signed mode, so they
                    // double as the "apply correction" enables
                    sign1_d   = signed_div_i & opdata1_i[WIDTH-1];
                    sign2_d   = signed_div_i & opdata2_i[WIDTH-1];
                    divisor_d = op2_mag;
                    work_d    = {{(WIDTH+1){1'b0}}, op1_mag};
                    cnt_d     = '0;
                    state_d   = (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
                end
            end
            DIV_BY_ZERO: begin
                work_d  = '0;
                state_d = annul_i ? DIV_FREE : DIV_END;
            end
            DIV_ON: begin
                if (annul_i) begin
                    state_d = DIV_FREE;
                end else if (cnt == CNT_LAST) begin
                    work_d  = {1'b0, rem_fix, quot_fix};
                    state_d = DIV_END;
                end else begin
                    work_d = diff[WIDTH+1] ? shifted
                                           : {diff[WIDTH:0], shifted[WIDTH-1:1], 1'b1};
                    cnt_d  = cnt + 1'b1;
                end
            end
            DIV_END: begin
                if (accept) begin
                    ready_d  = DIV_RESULT_READY;
                    result_d = work[2*WIDTH-1:0];
                end else begin
                    state_d = DIV_FREE;
                end
            end
            default: state_d = DIV_FREE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= DIV_FREE;
            cnt      <= '0;
            work     <= '0;
            divisor  <= '0;
            sign1    <= 1'b0;
            sign2    <= 1'b0;
            result_o <= '0;
            ready_o  <= DIV_RESULT_NOT_READY;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            work     <= work_d;
            divisor  <= divisor_d;
            sign1    <= sign1_d;
            sign2    <= sign2_d;
            result_o <= result_d;
            ready_o  <= ready_d;
        end
    end

endmodule
